seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU control decoder, plus two operands, and returns a result and zero flag over a valid/ready handshake. Logic and add/compare operations complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter to save area. It sits between the ID/EX register and the EX/MEM register; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `SHAMT_WIDTH`, $clog2(DATA_WIDTH) = 5, number of low `SrcB` bits used as shift amount
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `in_valid` input 1: operation offered
- `in_ready` output 1: block can accept; equals (state == IDLE)
- `Operation` input 4: ALU operation code (encoding below)
- `SrcA` input DATA_WIDTH: operand A
- `SrcB` input DATA_WIDTH: operand B / shift amount
- `out_valid` output 1: result available
- `out_ready` input 1: consumer takes result
- `ALUResult` output DATA_WIDTH: result
- `Zero` output 1: (ALUResult == 0)

## Operation
- Operation encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ
  - 1001 GE signed
  - 1010 NE
  - 1100 LT signed (also SLT)
  - 1011/1101/1110/1111: result 0
- Compare ops return {0..., flag}. The branch unit uses `ALUResult[0]` as "taken".
- ADD/SUB wrap modulo 2^DATA_WIDTH. No overflow output. LT/GE compare as two's complement.
- Shift amount is `SrcB[SHAMT_WIDTH-1:0]`; upper bits are ignored. SRL fills with 0. SRA replicates `SrcA[MSB]` on every step.
- Acceptance: `in_valid && in_ready` at a rising edge. `Operation`, `SrcA` and the shift amount are latched at that edge; later input changes are ignored.
- FSM states:
  - IDLE
    - accept a non-shift op → DONE, with the result registered.
    - accept a shift op with shamt = 0 → DONE, result = SrcA.
    - accept a shift op with shamt = k > 0 → SHIFT, work reg = SrcA, count = k.
  - SHIFT
    - each edge: work reg shifts 1 bit in the latched direction/type, count decrements.
    - on the edge where count goes 1 → 0: move to DONE, ALUResult = work reg.
  - DONE
    - `out_valid` = 1.
    - `out_ready` high at an edge → IDLE.
- No overlap: `in_ready` is 0 in SHIFT and DONE, so there is at least one bubble between operations.
- Asynchronous reset, including mid-SHIFT or while in DONE:
  - state → IDLE, count → 0, work reg → 0.
  - the in-flight op is discarded.

## Timing
- Reset values: `out_valid` 0, `ALUResult` 0, `Zero` 1, `in_ready` 1 (IDLE). Transfers offered while `reset` is high are ignored.
- Latency from the acceptance edge to `out_valid` high:
  - non-shift, or shift by 0: 1 cycle.
  - shift by k: k+1 cycles (max 32 at DATA_WIDTH 32).
- Throughput with `out_ready` held high:
  - one non-shift op every 2 cycles.
  - one shift op every k+2 cycles.
- `ALUResult`/`Zero` are registered. They are stable for the whole time `out_valid` is high, and hold their value after the handshake until the next result is written.
- `in_ready` depends only on state, with no combinational path from `in_valid`.
- `out_valid` does not depend on `out_ready`.
- `in_valid` and `out_ready` asserted together in DONE: the result is consumed and the block moves to IDLE. The new op is not accepted until the next edge.

## Test plan
- **ADD:** `Operation` 0010, `SrcA` 0x7FFFFFFF, `SrcB` 0x00000001 → `ALUResult` 0x80000000, `Zero` 0, `out_valid` high exactly 1 cycle after accept.
- **SUB and EQ:** `Operation` 0110, 5 − 5 → 0x0, `Zero` 1. Then `Operation` 1000, same operands → 0x1.
- **SRA:** `Operation` 0111, `SrcA` 0x80000000, `SrcB` 0xFFFFFFE4 (shamt 4) → 0xF8000000. `out_valid` 5 cycles after accept, `in_ready` 0 throughout.
- **Signed compares and unused code:** with `SrcA` 0xFFFFFFFF, `SrcB` 0x00000001:
  - 1100 → 0x1
  - 1001 → 0x0
  - 1010 → 0x1
  - 1111 → 0x0, `Zero` 1
- **Backpressure:** AND 0xF0F0F0F0 & 0xFF00FF00, hold `out_ready` 0 for 3 cycles → result 0xF000F000 and `out_valid` held stable, `in_ready` 0. Raise `out_ready` → IDLE next cycle, `in_ready` 1.
- **Reset mid-shift:** SLL 0x1 by 31, assert `reset` 10 cycles after accept → `out_valid` 0 and `ALUResult` 0 immediately. After release, OR 0x1 | 0x2 → 0x3 with 1-cycle latency.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the ID/EX stage and the sequential ALU.
// master: the upstream/downstream pipeline side; slave: the ALU itself.
interface seq_alu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            Operation;
   logic [DATA_WIDTH-1:0] SrcA;
   logic [DATA_WIDTH-1:0] SrcB;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] ALUResult;
   logic                  Zero;

   modport master (
      output in_valid, Operation, SrcA, SrcB, out_ready,
      input  in_ready, out_valid, ALUResult, Zero
   );

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, out_ready,
      output in_ready, out_valid, ALUResult, Zero
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU. Logic, arithmetic and compare ops finish
// in one cycle; shifts walk one bit per cycle through a work register.
// Results are held registered in DONE until the consumer takes them.
module seq_alu #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input logic     clk,
   input logic     reset,
   seq_alu_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_GE  = 4'b1001;
   localparam logic [3:0] OP_NE  = 4'b1010;
   localparam logic [3:0] OP_LT  = 4'b1100;

   localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = SHAMT_WIDTH'(1);
   localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = SHAMT_WIDTH'(0);

   logic [1:0]             state_r;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic [3:0]             op_r;
   logic [DATA_WIDTH-1:0]  work_r;
   logic [SHAMT_WIDTH-1:0] count_r;
   logic [DATA_WIDTH-1:0]  result_r;
   logic                   zero_r;

   logic [SHAMT_WIDTH-1:0] shamt_s;
   logic [DATA_WIDTH-1:0]  alu_res_s;
   logic [DATA_WIDTH-1:0]  step_s;
   logic                   start_shift_s;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Single-cycle result. Shift codes only reach here with a zero shift
   // amount, where the answer is SrcA unchanged.
   function automatic logic [DATA_WIDTH-1:0] alu_compute(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_XOR:  r = a ^ b;
         OP_SUB:  r = a - b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  r = a;
         OP_EQ:   r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
         OP_GE:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
         OP_NE:   r = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
         OP_LT:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: r = '0;
      endcase
      return r;
   endfunction

   // One bit of shift in the direction/type of the latched op.
   function automatic logic [DATA_WIDTH-1:0] shift_step(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] w
   );
      logic [DATA_WIDTH-1:0] r;
      r = w;
      case (op)
         OP_SLL:  r = {w[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, w[DATA_WIDTH-1:1]};
         OP_SRA:  r = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
         default: r = w;
      endcase
      return r;
   endfunction

   // Decode the offered op and the next shifter value.
   always_comb begin
      shamt_s       = bus.SrcB[SHAMT_WIDTH-1:0];
      alu_res_s     = alu_compute(bus.Operation, bus.SrcA, bus.SrcB);
      step_s        = shift_step(op_r, work_r);
      if (is_shift(bus.Operation) && (shamt_s != CNT_ZERO)) begin
         start_shift_s = 1'b1;
      end else begin
         start_shift_s = 1'b0;
      end
   end

   // Control FSM, shifter and registered result/flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         op_r        <= 4'b0000;
         work_r      <= '0;
         count_r     <= CNT_ZERO;
         result_r    <= '0;
         zero_r      <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  op_r       <= bus.Operation;
                  in_ready_r <= 1'b0;
                  if (start_shift_s) begin
                     state_r <= SHIFT;
                     work_r  <= bus.SrcA;
                     count_r <= shamt_s;
                  end else begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                     result_r    <= alu_res_s;
                     zero_r      <= (alu_res_s == '0);
                  end
               end
            end
            SHIFT: begin
               work_r  <= step_s;
               count_r <= count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= step_s;
                  zero_r      <= (step_s == '0);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               count_r     <= CNT_ZERO;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.ALUResult = result_r;
   assign bus.Zero      = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
module tb_seq_alu;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   seq_alu_if #(.DATA_WIDTH(32)) bus ();

   seq_alu #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one op; returns just after the acceptance edge with in_valid low.
   task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid  = 1'b1;
      bus.Operation = op;
      bus.SrcA      = a;
      bus.SrcB      = b;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
   endtask

   // Cycles from acceptance edge to out_valid (-1 if it never came).
   task automatic wait_valid(output int cycles, output logic saw_ready);
      int n;
      n = 1;
      saw_ready = 1'b0;
      while (!bus.out_valid && n < 40) begin
         if (bus.in_ready) saw_ready = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      cycles = bus.out_valid ? n : -1;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid  = 1'b1;
      bus.Operation = 4'b0010;
      bus.SrcA      = 32'h0000_0003;
      bus.SrcB      = 32'h0000_0004;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: out_valid=%b result=%h zero=%b in_ready=%b, required 0 00000000 1 1",
                  bus.out_valid, bus.ALUResult, bus.Zero, bus.in_ready);
      end
      bus.in_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ignored_offer: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_add();
      int   cyc;
      logic sr;
      offer(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 1) begin
         failures++;
         $display("FAIL add_latency: got %0d required 1", cyc);
      end
      checks++;
      if (bus.ALUResult !== 32'h8000_0000 || bus.Zero !== 1'b0) begin
         failures++;
         $display("FAIL add_result: got %h zero=%b required 80000000 zero=0", bus.ALUResult, bus.Zero);
      end
      consume();
   endtask

   task automatic test_sub_eq();
      int   cyc;
      logic sr;
      offer(4'b0110, 32'd5, 32'd5);
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 1 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
         failures++;
         $display("FAIL sub_zero: lat=%0d got %h zero=%b required lat=1 00000000 zero=1", cyc, bus.ALUResult, bus.Zero);
      end
      consume();
      offer(4'b1000, 32'd5, 32'd5);
      wait_valid(cyc, sr);
      checks++;
      if (bus.ALUResult !== 32'h1 || bus.Zero !== 1'b0) begin
         failures++;
         $display("FAIL eq_true: got %h zero=%b required 00000001 zero=0", bus.ALUResult, bus.Zero);
      end
      consume();
   endtask

   task automatic test_sra();
      int   cyc;
      logic sr;
      offer(4'b0111, 32'h8000_0000, 32'hFFFF_FFE4);
      bus.Operation = 4'b0100;
      bus.SrcA      = 32'h0000_0000;
      bus.SrcB      = 32'h0000_0001;
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 5) begin
         failures++;
         $display("FAIL sra_latency: got %0d required 5", cyc);
      end
      checks++;
      if (sr !== 1'b0) begin
         failures++;
         $display("FAIL sra_in_ready: in_ready seen high during shift, required low");
      end
      checks++;
      if (bus.ALUResult !== 32'hF800_0000) begin
         failures++;
         $display("FAIL sra_result: got %h required f8000000", bus.ALUResult);
      end
      consume();
   endtask

   task automatic test_compares();
      logic [3:0]  ops [4] = '{4'b1100, 4'b1001, 4'b1010, 4'b1111};
      logic [31:0] exp [4] = '{32'h1, 32'h0, 32'h1, 32'h0};
      int   cyc;
      logic sr;
      for (int i = 0; i < 4; i++) begin
         offer(ops[i], 32'hFFFF_FFFF, 32'h0000_0001);
         wait_valid(cyc, sr);
         checks++;
         if (cyc !== 1 || bus.ALUResult !== exp[i] || bus.Zero !== (exp[i] == 32'h0)) begin
            failures++;
            $display("FAIL compare_op%b: lat=%0d got %h zero=%b required lat=1 %h zero=%b",
                     ops[i], cyc, bus.ALUResult, bus.Zero, exp[i], (exp[i] == 32'h0));
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int   cyc;
      logic sr;
      offer(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_valid(cyc, sr);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'hF000_F000 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold%0d: out_valid=%b result=%h in_ready=%b required 1 f000f000 0",
                     i, bus.out_valid, bus.ALUResult, bus.in_ready);
         end
      end
      consume();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ALUResult !== 32'hF000_F000) begin
         failures++;
         $display("FAIL backpressure_release: in_ready=%b out_valid=%b result=%h required 1 0 f000f000",
                  bus.in_ready, bus.out_valid, bus.ALUResult);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      logic sr;
      // Shift amount taken from low 5 bits only: 0x20 means shift by 0.
      offer(4'b0100, 32'h1234_5678, 32'h0000_0020);
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 1 || bus.ALUResult !== 32'h1234_5678) begin
         failures++;
         $display("FAIL shift_zero: lat=%0d got %h required lat=1 12345678", cyc, bus.ALUResult);
      end
      consume();
      offer(4'b0101, 32'h8000_0000, 32'h0000_0001);
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 2 || bus.ALUResult !== 32'h4000_0000) begin
         failures++;
         $display("FAIL srl_one: lat=%0d got %h required lat=2 40000000", cyc, bus.ALUResult);
      end
      // Offer the next op while consuming: it must not be taken on this edge.
      bus.in_valid  = 1'b1;
      bus.Operation = 4'b0011;
      bus.SrcA      = 32'hA5A5_A5A5;
      bus.SrcB      = 32'h0F0F_0F0F;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL overlap_blocked: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'hAAAA_AAAA) begin
         failures++;
         $display("FAIL xor_after_bubble: out_valid=%b got %h required 1 aaaaaaaa", bus.out_valid, bus.ALUResult);
      end
      consume();
   endtask

   task automatic test_reset_mid_shift();
      int   cyc;
      logic sr;
      offer(4'b0100, 32'h0000_0001, 32'h0000_001F);
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL sll_in_flight: out_valid=%b in_ready=%b required 0 0", bus.out_valid, bus.in_ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_shift: out_valid=%b result=%h zero=%b in_ready=%b required 0 00000000 1 1",
                  bus.out_valid, bus.ALUResult, bus.Zero, bus.in_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      offer(4'b0001, 32'h0000_0001, 32'h0000_0002);
      wait_valid(cyc, sr);
      checks++;
      if (cyc !== 1 || bus.ALUResult !== 32'h3) begin
         failures++;
         $display("FAIL or_after_reset: lat=%0d got %h required lat=1 00000003", cyc, bus.ALUResult);
      end
      consume();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.Operation = 4'b0000;
      bus.SrcA      = 32'h0;
      bus.SrcB      = 32'h0;
      test_reset();
      test_add();
      test_sub_eq();
      test_sra();
      test_compares();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
